// File: rtl/sel_encoder.sv
// sel_encoder: captures one of eight level-sensitive request lines, encodes
// the winning index into a registered 3-bit code and holds it under a
// valid/ready handshake. Winner selection is round-robin from the last
// transferred index (RR_EN=1) or fixed lowest-index-first (RR_EN=0).
module sel_encoder #(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel0,
  input  logic sel1,
  input  logic sel2,
  input  logic sel3,
  input  logic sel4,
  input  logic sel5,
  input  logic sel6,
  input  logic sel7,
  input  logic en,
  input  logic out_ready,
  output logic adr0,
  output logic adr1,
  output logic adr2,
  output logic out_valid,
  output logic multi
);

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  logic       state_q, state_d;
  logic [2:0] adr_q, adr_d;
  logic       multi_q, multi_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] sel_vec;
  logic       xfer;
  logic       any_sel;
  logic [2:0] ptr_eff;
  logic [2:0] win_rr;
  logic [2:0] win_fp;
  logic [2:0] win;
  logic [3:0] pop_cnt;

  assign sel_vec = {sel7, sel6, sel5, sel4, sel3, sel2, sel1, sel0};
  assign any_sel = |sel_vec;
  assign xfer    = (state_q == HOLD) && out_ready;
  // A transfer on this edge moves the pointer first, so the back-to-back
  // winner is searched from the code just handed over.
  assign ptr_eff = xfer ? adr_q : ptr_q;

  // Round-robin search: ptr+1 .. ptr+8 (mod 8), so sel[ptr] is checked last.
  always_comb begin
    logic found;
    win_rr = '0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && sel_vec[3'(ptr_eff + 3'(k))]) begin
        win_rr = 3'(ptr_eff + 3'(k));
        found  = 1'b1;
      end
    end
  end

  // Fixed priority: scan downward so the lowest asserted index is kept.
  always_comb begin
    win_fp = '0;
    for (int i = 7; i >= 0; i--) begin
      if (sel_vec[i]) win_fp = 3'(i);
    end
  end

  assign win = (RR_EN != 0) ? win_rr : win_fp;

  // Population count of the request lines, used to flag multi-hot captures.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + {3'b000, sel_vec[i]};
    end
  end

  // Next-state: capture from IDLE or on a transfer, otherwise hold the code.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (xfer) ptr_d = adr_q;
    if (((state_q == IDLE) || xfer) && en && any_sel) begin
      adr_d   = win;
      multi_d = (pop_cnt >= 4'd2);
      state_d = HOLD;
    end else if (xfer) begin
      state_d = IDLE;
    end
  end

  // State registers with synchronous active-low reset; ptr=7 makes the
  // first round-robin search start at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= 3'd0;
      multi_q <= 1'b0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign adr0      = adr_q[2];
  assign adr1      = adr_q[1];
  assign adr2      = adr_q[0];
  assign multi     = multi_q;

endmodule

// File: doc/sel_encoder.md
SEL_ENCODER -- requirements
Module: sel_encoder

Interface
REQ-001 The module SHALL have one parameter: RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority (lowest index wins).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The module SHALL have ports sel0..sel7, input, 1 bit each, level-sensitive row request lines (multi-hot allowed).
REQ-005 The module SHALL have port en, input, 1 bit, capture enable that gates new captures only.
REQ-006 The module SHALL have port out_ready, input, 1 bit, consumer accepts the current code.
REQ-007 The module SHALL have ports adr0, adr1, adr2, output, 1 bit each, the registered encoded index, with adr0 as the MSB: index = {adr0, adr1, adr2}.
REQ-008 The module SHALL have port out_valid, output, 1 bit, indicating that adr0..adr2 hold an unaccepted code.
REQ-009 The module SHALL have port multi, output, 1 bit, registered with the code and set when more than one sel line was asserted at capture.

Function
REQ-010 The module SHALL implement exactly two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-011 In IDLE, with en=1 and any sel asserted at a rising edge, the module SHALL load the winner index and multi, set out_valid, and move to HOLD, giving 1-cycle latency from request to out_valid.
REQ-012 In IDLE, with en=0 or no sel asserted, the module SHALL stay in IDLE, with adr and multi holding their previous values.
REQ-013 In HOLD, adr0..adr2, multi and out_valid SHALL stay stable until a transfer (out_valid=1 and out_ready=1 at a rising edge); sel changes and en=0 are ignored.
REQ-014 On a transfer, the module SHALL set the last-grant pointer ptr (3 bits) to the transferred index.
REQ-015 On a transfer in the same edge where en=1 and any sel is asserted, the module SHALL load the next winner (arbitrated using the updated ptr), keep out_valid=1 and stay in HOLD, giving back-to-back codes with no bubble.
REQ-016 On a transfer in the same edge where en=0 or no sel is asserted, the module SHALL clear out_valid and go to IDLE.
REQ-017 With RR_EN=1, the winner SHALL be the first asserted line searching ptr+1, ptr+2, ..., ptr modulo 8, so the search wraps 7 to 0.
REQ-018 With RR_EN=1, if only sel[ptr] is asserted, it SHALL win (after full wrap).
REQ-019 With RR_EN=0, the winner SHALL be the lowest asserted index; ptr is still updated but unused.
REQ-020 The multi output SHALL be 1 exactly when the population count of sel0..sel7 at capture is at least 2; a single asserted line gives multi=0.
REQ-021 out_ready SHALL be ignored when out_valid=0.
REQ-022 The module SHALL have no combinational path from any input to any output.

Reset
REQ-023 When rst_n=0 at a rising edge, the module SHALL set out_valid=0, adr0=adr1=adr2=0, multi=0, ptr=7 and state=IDLE, regardless of en, sel and out_ready.
REQ-024 A reset asserted while in HOLD SHALL discard the pending code, with no transfer counted even if out_ready=1 on that edge.
REQ-025 With ptr=7 after reset, the first round-robin search SHALL start at index 0.
REQ-026 On the first edge with rst_n=1, the module SHALL capture normally if en=1 and sel is non-zero.

Verification
REQ-027 The bench SHALL cover: reset, then sel3 only, en=1, out_ready=1 -> next cycle adr=011 (adr0=0, adr1=1, adr2=1), out_valid=1, multi=0; the following cycle out_valid=0.
REQ-028 The bench SHALL cover: RR_EN=1, sel0, sel5 and sel7 held, en=1, out_ready=1 -> codes 0, 5, 7, 0, 5 on consecutive cycles, multi=1 on each, out_valid never drops.
REQ-029 The bench SHALL cover: RR_EN=0 with the same stimulus -> code 0 every cycle, multi=1.
REQ-030 The bench SHALL cover: sel2 captured, out_ready=0 for 4 cycles while sel switches to sel6 and en goes to 0 -> adr stays 010 and out_valid=1 throughout; after out_ready=1 for one edge, out_valid=0.
REQ-031 The bench SHALL cover: in HOLD with code 4, rst_n=0 and out_ready=1 on the same edge -> out_valid=0, adr=000, multi=0; after release with sel7 and sel1 asserted (RR_EN=1) -> first code 1.
REQ-032 The bench SHALL cover: all eight sel lines asserted, RR_EN=1, out_ready=1 -> codes 0 through 7 then 0 again, confirming 7-to-0 wrap.
